// File: rtl/run_control_pkg.sv
// Shared encodings and defaults for the Tamarac run/step controller.
package run_control_pkg;

  typedef enum logic [1:0] {
    RC_HALT  = 2'd0,
    RC_RUN   = 2'd1,
    RC_BURST = 2'd2
  } rc_state_e;

  localparam int unsigned RC_DBNC_CYCLES_DEFAULT = 250000;

  function automatic int unsigned rc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_control_key.sv
// Board key front end: 2-FF synchroniser, level debouncer and press pulse.
module key_conditioner
  import run_control_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES = RC_DBNC_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DBNC_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          key_on;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The synchroniser is left out of reset so a key held through reset still
  // reads as pressed afterwards and cannot arm the pulse until it is released.
  always_ff @(posedge clock) begin
    sync1_q <= key_n;
    sync2_q <= sync1_q;
  end

  assign key_on = ~sync2_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (key_on != level_q) begin
      if (cnt_q == CW'(DBNC_CYCLES - 1)) begin
        level_d = key_on;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    armed_d = armed_q | (~level_q & ~key_on);
    press   = armed_q & level_d & ~level_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/run_control.sv
// HALT/RUN/BURST run controller with PC breakpoints and an instruction counter.
module run_control
  import run_control_pkg::*;
#(
  parameter int unsigned PC_W        = 13,
  parameter int unsigned N_BP        = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DBNC_CYCLES = RC_DBNC_CYCLES_DEFAULT,
  localparam int unsigned IDX_W      = rc_idx_w(N_BP)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 key_mode_n,
  input  logic                 key_step_n,
  input  logic                 key_burst_n,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic [N_BP*PC_W-1:0] bp_addr,
  input  logic [N_BP-1:0]      bp_valid,
  input  logic [PC_W-1:0]      pc,
  input  logic                 fetch,
  output logic                 step_en,
  output logic                 running,
  output logic                 bp_hit,
  output logic [IDX_W-1:0]     bp_index,
  output logic [CNT_W-1:0]     step_count
);

  logic mode_p, step_p, burst_p;

  key_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_key_mode (
    .clock(clock), .reset(reset), .key_n(key_mode_n), .press(mode_p)
  );
  key_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_key_step (
    .clock(clock), .reset(reset), .key_n(key_step_n), .press(step_p)
  );
  key_conditioner #(.DBNC_CYCLES(DBNC_CYCLES)) u_key_burst (
    .clock(clock), .reset(reset), .key_n(key_burst_n), .press(burst_p)
  );

  logic [N_BP-1:0]  hit;
  logic             match;
  logic [IDX_W-1:0] match_idx;

  for (genvar gi = 0; gi < N_BP; gi++) begin : g_bp
    assign hit[gi] = bp_valid[gi] && (bp_addr[gi*PC_W +: PC_W] == pc);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    match_idx = '0;
    for (int i = N_BP - 1; i >= 0; i--) begin
      if (hit[i]) match_idx = IDX_W'(i);
    end
    match = |hit;
  end

  rc_state_e        state_q, state_d;
  logic             skip_q, skip_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             bp_hit_q, bp_hit_d;
  logic [IDX_W-1:0] bp_idx_q, bp_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bp_stop, burst_done, fetch_step;

  assign bp_stop    = fetch && match && !skip_q;
  assign burst_done = fetch && (remain_q == '0);
  assign fetch_step = fetch && step_en;

  always_comb begin
    case (state_q)
      RC_HALT:  step_en = step_p && !mode_p && !burst_p;
      RC_RUN:   step_en = !bp_stop;
      RC_BURST: step_en = !(bp_stop || burst_done);
      default:  step_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    remain_d = remain_q;
    bp_hit_d = bp_hit_q;
    bp_idx_d = bp_idx_q;
    count_d  = count_q;

    if (fetch_step) begin
      skip_d  = 1'b0;
      count_d = count_q + 1'b1;
    end

    case (state_q)
      RC_HALT: begin
        if (mode_p) begin
          state_d  = RC_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (burst_p && (burst_len != '0)) begin
          state_d  = RC_BURST;
          remain_d = burst_len;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      RC_RUN: begin
        if (bp_stop) begin
          state_d  = RC_HALT;
          bp_hit_d = 1'b1;
          bp_idx_d = match_idx;
        end else if (mode_p) begin
          state_d = RC_HALT;
        end
      end
      RC_BURST: begin
        if (fetch_step) remain_d = remain_q - 1'b1;
        if (bp_stop) begin
          state_d  = RC_HALT;
          bp_hit_d = 1'b1;
          bp_idx_d = match_idx;
        end else if (burst_done || mode_p) begin
          state_d = RC_HALT;
        end
      end
      default: state_d = RC_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= RC_HALT;
      skip_q   <= 1'b0;
      remain_q <= '0;
      bp_hit_q <= 1'b0;
      bp_idx_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      remain_q <= remain_d;
      bp_hit_q <= bp_hit_d;
      bp_idx_q <= bp_idx_d;
      count_q  <= count_d;
    end
  end

  assign running    = (state_q != RC_HALT);
  assign bp_hit     = bp_hit_q;
  assign bp_index   = bp_idx_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control with a 4-cycle-per-instruction controller model.
module tb_run_control;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_mode_n = 1'b1;
  logic        key_step_n = 1'b1;
  logic        key_burst_n = 1'b1;
  logic [7:0]  burst_len = '0;
  logic [25:0] bp_addr = '0;
  logic [1:0]  bp_valid = '0;
  logic [12:0] pc = '0;
  logic        fetch = 1'b1;
  logic        step_en;
  logic        running;
  logic        bp_hit;
  logic [0:0]  bp_index;
  logic [7:0]  step_count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ustep = 0;
  logic en_s = 1'b0;

  run_control #(.PC_W(13), .N_BP(2), .CNT_W(8), .DBNC_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .key_mode_n(key_mode_n), .key_step_n(key_step_n), .key_burst_n(key_burst_n),
    .burst_len(burst_len), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .pc(pc), .fetch(fetch),
    .step_en(step_en), .running(running), .bp_hit(bp_hit),
    .bp_index(bp_index), .step_count(step_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock per iteration; the controller model advances on enabled cycles.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      en_s = step_en;
      @(posedge clock);
      #1;
      if (en_s) begin
        if (fetch) pc = pc + 13'd1;
        ustep = (ustep + 1) % 4;
      end
      fetch = (ustep == 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    pc    = '0;
    ustep = 0;
    fetch = 1'b1;
  endtask

  task automatic run_until_halt(input int max);
    int k;
    k = 0;
    while (running && k < max) begin
      cyc(1);
      k++;
    end
    chk("halt_in_budget", {31'd0, running}, 32'd0);
    chk("halt_cycle_step_en", {31'd0, en_s}, 32'd0);
  endtask

  initial begin
    int n_run;
    int n_en;
    int pos;

    // 1: key held through reset gives no pulse; a clean press starts RUN at +6
    key_mode_n = 1'b0;
    do_reset();
    @(negedge clock);
    chk("rst_step_en", {31'd0, step_en}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_bp_index", {31'd0, bp_index}, 32'd0);
    chk("rst_step_count", {24'd0, step_count}, 32'd0);
    n_run = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); n_run += running; end
    key_mode_n = 1'b1;
    for (int i = 0; i < 12; i++) begin cyc(1); n_run += running; end
    chk("held_key_no_pulse", n_run, 0);
    key_mode_n = 1'b0;
    cyc(5);
    chk("mode_latency_5", {31'd0, running}, 32'd0);
    cyc(1);
    chk("mode_latency_6", {31'd0, running}, 32'd1);
    key_mode_n = 1'b1;
    cyc(8);

    // 2: bouncing step key yields exactly one step_en, 6 cycles after settling
    do_reset();
    n_en = 0;
    pos  = 0;
    key_step_n = 1'b0; cyc(1); n_en += en_s;
    key_step_n = 1'b1; cyc(1); n_en += en_s;
    key_step_n = 1'b0; cyc(1); n_en += en_s;
    key_step_n = 1'b1; cyc(1); n_en += en_s;
    key_step_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (en_s) begin n_en++; pos = i; end
    end
    chk("step_pulse_count", n_en, 1);
    chk("step_pulse_pos", pos, 6);
    chk("step_count_1", {24'd0, step_count}, 32'd1);
    key_step_n = 1'b1;
    cyc(10);

    // 3: breakpoint at 0x010, then resume past it
    do_reset();
    bp_addr  = {13'h000, 13'h010};
    bp_valid = 2'b01;
    key_mode_n = 1'b0; cyc(6);
    chk("bp_run_start", {31'd0, running}, 32'd1);
    key_mode_n = 1'b1;
    run_until_halt(200);
    chk("bp_pc", {19'd0, pc}, 32'h010);
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    chk("bp_index_0", {31'd0, bp_index}, 32'd0);
    chk("bp_step_count", {24'd0, step_count}, 32'h10);
    key_mode_n = 1'b0; cyc(6);
    key_mode_n = 1'b1; cyc(8);
    chk("resume_running", {31'd0, running}, 32'd1);
    chk("resume_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("resume_count", {24'd0, step_count}, 32'h12);

    // 4: burst of 3 from 0x020, then burst_len = 0 has no effect
    do_reset();
    bp_valid  = 2'b00;
    pc        = 13'h020;
    burst_len = 8'd3;
    key_burst_n = 1'b0; cyc(6);
    chk("burst_start", {31'd0, running}, 32'd1);
    key_burst_n = 1'b1;
    run_until_halt(100);
    chk("burst_count", {24'd0, step_count}, 32'd3);
    chk("burst_pc", {19'd0, pc}, 32'h023);
    chk("burst_bp_hit", {31'd0, bp_hit}, 32'd0);
    cyc(8);
    burst_len = 8'd0;
    key_burst_n = 1'b0; cyc(6);
    chk("burst_zero_halt", {31'd0, running}, 32'd0);
    key_burst_n = 1'b1; cyc(8);

    // 5: index selection and priority; mode abort of a burst
    do_reset();
    bp_addr  = {13'h003, 13'h000};
    bp_valid = 2'b10;
    key_mode_n = 1'b0; cyc(6); key_mode_n = 1'b1;
    run_until_halt(100);
    chk("bp1_pc", {19'd0, pc}, 32'h003);
    chk("bp1_index", {31'd0, bp_index}, 32'd1);
    cyc(8);
    bp_addr  = {13'h005, 13'h005};
    bp_valid = 2'b11;
    key_mode_n = 1'b0; cyc(6); key_mode_n = 1'b1;
    run_until_halt(100);
    chk("bp_prio_pc", {19'd0, pc}, 32'h005);
    chk("bp_prio_index", {31'd0, bp_index}, 32'd0);
    chk("bp_prio_hit", {31'd0, bp_hit}, 32'd1);
    cyc(8);
    do_reset();
    bp_valid  = 2'b00;
    burst_len = 8'd10;
    key_burst_n = 1'b0; cyc(6);
    key_burst_n = 1'b1;
    key_mode_n  = 1'b0; cyc(6);
    chk("abort_running", {31'd0, running}, 32'd0);
    chk("abort_count", {24'd0, step_count}, 32'd2);
    chk("abort_bp_hit", {31'd0, bp_hit}, 32'd0);
    key_mode_n = 1'b1; cyc(8);

    // 6: counter wrap and reset mid-run
    do_reset();
    burst_len = 8'd255;
    key_burst_n = 1'b0; cyc(6); key_burst_n = 1'b1;
    run_until_halt(1200);
    chk("preload_ff", {24'd0, step_count}, 32'hFF);
    key_step_n = 1'b0; cyc(6);
    chk("count_wrap", {24'd0, step_count}, 32'd0);
    key_step_n = 1'b1; cyc(8);
    key_mode_n = 1'b0; cyc(6); key_mode_n = 1'b1; cyc(10);
    chk("pre_reset_running", {31'd0, running}, 32'd1);
    reset = 1'b0;
    cyc(1);
    @(negedge clock);
    chk("midrun_rst_step_en", {31'd0, step_en}, 32'd0);
    chk("midrun_rst_running", {31'd0, running}, 32'd0);
    chk("midrun_rst_count", {24'd0, step_count}, 32'd0);
    chk("midrun_rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    reset = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
